// File: rtl/cosim_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the cosim channel arbiter.
package cosim_arb_pkg;

  localparam int unsigned CHAN_TAG_BITS   = 8;
  localparam int unsigned COUNTER_BITS    = 32;
  localparam int unsigned DROP_COUNT_BITS = 16;
  // An 8-bit tag can address at most this many channels.
  localparam int unsigned MAX_CHANNELS    = 256;

  typedef enum logic {InEmpty, InFull} in_state_e;
  typedef enum logic {HoldEmpty, HoldFull} eg_state_e;

  // First requester at or after (last + 1) mod num. Returns 0 when nothing requests.
  function automatic logic [CHAN_TAG_BITS-1:0] rr_next(input logic [MAX_CHANNELS-1:0]  req,
                                                       input logic [CHAN_TAG_BITS-1:0] last,
                                                       input int unsigned              num);
    logic [CHAN_TAG_BITS-1:0] pick;
    logic                     found;
    int unsigned              idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_CHANNELS; k++) begin
      idx = 32'(last) + k;
      // last < num and k <= num, so a single subtraction wraps the index.
      if (idx >= num) idx = idx - num;
      if (k <= num && !found && req[idx[CHAN_TAG_BITS-1:0]]) begin
        pick  = idx[CHAN_TAG_BITS-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cosim_rr_arbiter.sv
// Round-robin arbiter: combinational grant from the request vector and a last-grant register
// that moves to the current grant whenever the caller accepts it (advance).
module cosim_rr_arbiter
  import cosim_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [IdxW-1:0]    grant,
  output logic               grant_valid
);

  logic [IdxW-1:0]          last_q;
  logic [MAX_CHANNELS-1:0]  req_ext;
  logic [CHAN_TAG_BITS-1:0] last_ext;

  // Widen to the package function's fixed operand sizes and pick the next requester.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    last_ext               = CHAN_TAG_BITS'(last_q);
    grant                  = IdxW'(rr_next(req_ext, last_ext, NUM_REQ));
    grant_valid            = |req;
  end

  // Last grant starts at the top index so channel 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= IdxW'(NUM_REQ - 1);
    end else if (advance) begin
      last_q <= grant;
    end
  end

endmodule

// File: rtl/cosim_ep_channel_arbiter.sv
// Shares one cosim endpoint between NUM_CHANNELS valid/ready channel pairs.
// Ingress: round-robin pick, tag prefixed in byte 0. Egress: tag stripped, payload steered.
// Optional statistics counters are built when COSIM_ARB_STATS_EN is defined.
module cosim_ep_channel_arbiter
  import cosim_arb_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned PAYLOAD_BITS = 32,
  localparam int unsigned EP_BITS     = PAYLOAD_BITS + CHAN_TAG_BITS
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_CHANNELS-1:0]              ch_in_valid,
  output logic [NUM_CHANNELS-1:0]              ch_in_ready,
  input  logic [NUM_CHANNELS*PAYLOAD_BITS-1:0] ch_in_data,
  output logic [NUM_CHANNELS-1:0]              ch_out_valid,
  input  logic [NUM_CHANNELS-1:0]              ch_out_ready,
  output logic [PAYLOAD_BITS-1:0]              ch_out_data,
  output logic                                 ep_in_valid,
  input  logic                                 ep_in_ready,
  output logic [EP_BITS-1:0]                   ep_in_data,
  input  logic                                 ep_out_valid,
  output logic                                 ep_out_ready,
  input  logic [EP_BITS-1:0]                   ep_out_data,
  output logic [DROP_COUNT_BITS-1:0]           drop_count,
  output logic [NUM_CHANNELS*COUNTER_BITS-1:0] msg_count
);

  localparam int unsigned IdxW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  // ---------------------------------------------------------------------------------------------
  // Ingress
  // ---------------------------------------------------------------------------------------------
  in_state_e                in_st_q, in_st_d;
  logic [EP_BITS-1:0]       in_data_q, in_data_d;
  logic [IdxW-1:0]          grant;
  logic                     grant_valid;
  logic                     capture_ok;
  logic                     in_capture;
  logic [PAYLOAD_BITS-1:0]  in_sel_data;

  cosim_rr_arbiter #(
    .NUM_REQ (NUM_CHANNELS)
  ) u_rr_arbiter (
    .clk         (clk),
    .rstn        (rstn),
    .req         (ch_in_valid),
    .advance     (in_capture),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Payload mux for the granted channel.
  always_comb begin
    in_sel_data = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (grant == IdxW'(i)) in_sel_data = ch_in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  // Ingress next state, capture decision and one-hot accept.
  always_comb begin
    in_st_d     = in_st_q;
    in_data_d   = in_data_q;
    // Loading is allowed when empty or when the held message leaves this same cycle.
    capture_ok  = (in_st_q == InEmpty) || ep_in_ready;
    in_capture  = rstn && capture_ok && grant_valid;
    ch_in_ready = '0;
    if (in_capture) begin
      in_data_d = {in_sel_data, CHAN_TAG_BITS'(grant)};
      in_st_d   = InFull;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (grant == IdxW'(i)) ch_in_ready[i] = 1'b1;
      end
    end else if (in_st_q == InFull && ep_in_ready) begin
      in_st_d = InEmpty;
    end
  end

  // Ingress output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_st_q   <= InEmpty;
      in_data_q <= '0;
    end else begin
      in_st_q   <= in_st_d;
      in_data_q <= in_data_d;
    end
  end

  assign ep_in_valid = (in_st_q == InFull);
  assign ep_in_data  = in_data_q;

  // ---------------------------------------------------------------------------------------------
  // Egress
  // ---------------------------------------------------------------------------------------------
  eg_state_e               eg_st_q, eg_st_d;
  logic [PAYLOAD_BITS-1:0] eg_data_q, eg_data_d;
  logic [IdxW-1:0]         eg_tag_q, eg_tag_d;
  logic                    out_xfer;
  logic                    eg_capture;
  logic                    tag_ok;

  // Egress next state, endpoint ready and channel steering.
  always_comb begin
    eg_st_d      = eg_st_q;
    eg_data_d    = eg_data_q;
    eg_tag_d     = eg_tag_q;
    ch_out_valid = '0;
    out_xfer     = 1'b0;
    if (eg_st_q == HoldFull) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (eg_tag_q == IdxW'(i)) begin
          ch_out_valid[i] = 1'b1;
          // Only the addressed channel's ready counts; no bypass of a stalled head.
          out_xfer        = ch_out_ready[i];
        end
      end
    end
    ep_out_ready = rstn && ((eg_st_q == HoldEmpty) || out_xfer);
    eg_capture   = ep_out_valid && ep_out_ready;
    tag_ok       = 32'(ep_out_data[CHAN_TAG_BITS-1:0]) < NUM_CHANNELS;
    if (eg_capture && tag_ok) begin
      eg_data_d = ep_out_data[EP_BITS-1:CHAN_TAG_BITS];
      eg_tag_d  = IdxW'(ep_out_data[CHAN_TAG_BITS-1:0]);
      eg_st_d   = HoldFull;
    end else if (eg_capture || out_xfer) begin
      // Bad tags are discarded; a completed transfer with nothing new empties the holder.
      eg_st_d = HoldEmpty;
    end
  end

  // Egress holding register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      eg_st_q   <= HoldEmpty;
      eg_data_q <= '0;
      eg_tag_q  <= '0;
    end else begin
      eg_st_q   <= eg_st_d;
      eg_data_q <= eg_data_d;
      eg_tag_q  <= eg_tag_d;
    end
  end

  assign ch_out_data = eg_data_q;

  // ---------------------------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------------------------
`ifdef COSIM_ARB_STATS_EN
  logic [NUM_CHANNELS-1:0][COUNTER_BITS-1:0] msg_count_q;
  logic [DROP_COUNT_BITS-1:0]                drop_count_q;

  // Per-channel capture counters (wrapping) and saturating bad-tag counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      msg_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (in_capture && grant == IdxW'(i)) msg_count_q[i] <= msg_count_q[i] + 1'b1;
      end
      if (eg_capture && !tag_ok && drop_count_q != '1) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  assign msg_count  = msg_count_q;
  assign drop_count = drop_count_q;
`else
  assign msg_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_cosim_ep_channel_arbiter.sv
// Directed self-checking bench for cosim_ep_channel_arbiter (4 channels, 32-bit payload).
module tb_cosim_ep_channel_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned PB = 32;
  localparam int unsigned EB = PB + 8;

  logic            clk;
  logic            rstn;
  logic [N-1:0]    ch_in_valid;
  logic [N-1:0]    ch_in_ready;
  logic [N*PB-1:0] ch_in_data;
  logic [N-1:0]    ch_out_valid;
  logic [N-1:0]    ch_out_ready;
  logic [PB-1:0]   ch_out_data;
  logic            ep_in_valid;
  logic            ep_in_ready;
  logic [EB-1:0]   ep_in_data;
  logic            ep_out_valid;
  logic            ep_out_ready;
  logic [EB-1:0]   ep_out_data;
  logic [15:0]     drop_count;
  logic [N*32-1:0] msg_count;

  int checks;
  int failures;

  cosim_ep_channel_arbiter #(
    .NUM_CHANNELS (N),
    .PAYLOAD_BITS (PB)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ch_in_valid  (ch_in_valid),
    .ch_in_ready  (ch_in_ready),
    .ch_in_data   (ch_in_data),
    .ch_out_valid (ch_out_valid),
    .ch_out_ready (ch_out_ready),
    .ch_out_data  (ch_out_data),
    .ep_in_valid  (ep_in_valid),
    .ep_in_ready  (ep_in_ready),
    .ep_in_data   (ep_in_data),
    .ep_out_valid (ep_out_valid),
    .ep_out_ready (ep_out_ready),
    .ep_out_data  (ep_out_data),
    .drop_count   (drop_count),
    .msg_count    (msg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    ch_in_valid  = '0;
    ch_in_data   = '0;
    ch_out_ready = '0;
    ep_in_ready  = 1'b0;
    ep_out_valid = 1'b0;
    ep_out_data  = '0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstn         = 1'b0;
    ch_in_valid  = '0;
    ch_in_data   = '0;
    ch_out_ready = '0;
    ep_in_ready  = 1'b0;
    ep_out_valid = 1'b0;
    ep_out_data  = '0;
    tick();
    tick();
    checks++;
    if (ep_out_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ep_out_ready_low got=%b exp=0", ep_out_ready);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (ep_out_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ep_out_ready_after got=%b exp=1", ep_out_ready);
    end
    checks++;
    if ({ep_in_valid, ch_in_ready, ch_out_valid} !== 9'b0) begin
      failures++;
      $display("FAIL reset_idle_outputs got=%b exp=0", {ep_in_valid, ch_in_ready, ch_out_valid});
    end
    checks++;
    if (drop_count !== 16'h0 || msg_count !== '0) begin
      failures++;
      $display("FAIL reset_counters drop=%h msg=%h exp=0", drop_count, msg_count);
    end
    // Channel 2 sends one message.
    ch_in_valid         = 4'b0100;
    ch_in_data[2*PB +: PB] = 32'hDEADBEEF;
    #1;
    checks++;
    if (ch_in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL ch2_accept got=%b exp=0100", ch_in_ready);
    end
    tick();
    ch_in_valid = '0;
    #1;
    checks++;
    if (ep_in_valid !== 1'b1 || ep_in_data !== {32'hDEADBEEF, 8'h02}) begin
      failures++;
      $display("FAIL ch2_ingress valid=%b data=%h exp=1 deadbeef02", ep_in_valid, ep_in_data);
    end
    ep_in_ready = 1'b1;
    tick();
    checks++;
    if (ep_in_valid !== 1'b0) begin
      failures++;
      $display("FAIL ch2_drain valid=%b exp=0", ep_in_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [EB-1:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) ch_in_data[i*PB +: PB] = 32'hC0 + 32'(i);
    ch_in_valid = 4'b1111;
    ep_in_ready = 1'b1;
    #1;
    checks++;
    if (ch_in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rr_first_grant got=%b exp=0001", ch_in_ready);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) ch_in_valid = '0;
      exp = {32'hC0 + 32'(k % 4), 8'(k % 4)};
      checks++;
      if (ep_in_valid !== 1'b1 || ep_in_data !== exp) begin
        failures++;
        $display("FAIL rr_seq_%0d valid=%b data=%h exp=1 %h", k, ep_in_valid, ep_in_data, exp);
      end
    end
`ifdef COSIM_ARB_STATS_EN
    exp = '0;
    checks++;
    if (msg_count !== {32'd1, 32'd1, 32'd2, 32'd2}) begin
      failures++;
      $display("FAIL rr_msg_count got=%h exp=1,1,2,2", msg_count);
    end
`else
    checks++;
    if (msg_count !== '0) begin
      failures++;
      $display("FAIL rr_msg_count_off got=%h exp=0", msg_count);
    end
`endif
    tick();
    checks++;
    if (ep_in_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain valid=%b exp=0", ep_in_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ch_in_data[1*PB +: PB] = 32'h11110001;
    ch_in_data[3*PB +: PB] = 32'h33330003;
    ch_in_valid = 4'b1010;
    ep_in_ready = 1'b0;
    #1;
    checks++;
    if (ch_in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_first_accept got=%b exp=0010", ch_in_ready);
    end
    tick();
    ch_in_valid = 4'b1000;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ch_in_ready !== 4'b0000 || ep_in_valid !== 1'b1 ||
          ep_in_data !== {32'h11110001, 8'h01}) begin
        failures++;
        $display("FAIL bp_hold_%0d ready=%b valid=%b data=%h exp=0000 1 1111000101",
                 c, ch_in_ready, ep_in_valid, ep_in_data);
      end
      tick();
    end
    ep_in_ready = 1'b1;
    #1;
    checks++;
    if (ch_in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_release_accept got=%b exp=1000", ch_in_ready);
    end
    tick();
    ch_in_valid = '0;
    #1;
    checks++;
    if (ep_in_valid !== 1'b1 || ep_in_data !== {32'h33330003, 8'h03}) begin
      failures++;
      $display("FAIL bp_second valid=%b data=%h exp=1 3333000303", ep_in_valid, ep_in_data);
    end
    tick();
    checks++;
    if (ep_in_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain valid=%b exp=0", ep_in_valid);
    end
  endtask

  task automatic test_egress();
    do_reset();
    ep_out_valid = 1'b1;
    ep_out_data  = {32'h12345678, 8'h03};
    tick();
    ep_out_valid = 1'b0;
    ep_out_data  = '0;
    // Other channels ready must not let the head through.
    ch_out_ready = 4'b0111;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (ch_out_valid !== 4'b1000 || ch_out_data !== 32'h12345678 || ep_out_ready !== 1'b0) begin
        failures++;
        $display("FAIL eg_hold_%0d valid=%b data=%h epr=%b exp=1000 12345678 0",
                 c, ch_out_valid, ch_out_data, ep_out_ready);
      end
      tick();
    end
    ch_out_ready = 4'b1000;
    #1;
    checks++;
    if (ep_out_ready !== 1'b1) begin
      failures++;
      $display("FAIL eg_ready_same_cycle got=%b exp=1", ep_out_ready);
    end
    tick();
    ch_out_ready = '0;
    #1;
    checks++;
    if (ch_out_valid !== 4'b0000 || ep_out_ready !== 1'b1) begin
      failures++;
      $display("FAIL eg_after_xfer valid=%b epr=%b exp=0000 1", ch_out_valid, ep_out_ready);
    end
  endtask

  task automatic test_bad_tag();
    do_reset();
    ep_out_valid = 1'b1;
    ep_out_data  = {32'hCAFEF00D, 8'h09};
    tick();
    ep_out_valid = 1'b0;
    #1;
    checks++;
    if (ch_out_valid !== 4'b0000 || ep_out_ready !== 1'b1) begin
      failures++;
      $display("FAIL bad_tag_discard valid=%b epr=%b exp=0000 1", ch_out_valid, ep_out_ready);
    end
`ifdef COSIM_ARB_STATS_EN
    checks++;
    if (drop_count !== 16'd1) begin
      failures++;
      $display("FAIL bad_tag_drop_count got=%0d exp=1", drop_count);
    end
`else
    checks++;
    if (drop_count !== 16'd0) begin
      failures++;
      $display("FAIL bad_tag_drop_count_off got=%0d exp=0", drop_count);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    do_reset();
    ch_in_data[0 +: PB] = 32'hAAAA5555;
    ch_in_valid  = 4'b0001;
    ep_in_ready  = 1'b0;
    ep_out_valid = 1'b1;
    ep_out_data  = {32'hBBBB6666, 8'h01};
    ch_out_ready = '0;
    tick();
    ch_in_valid  = '0;
    ep_out_valid = 1'b0;
    #1;
    checks++;
    if (ep_in_valid !== 1'b1 || ch_out_valid !== 4'b0010) begin
      failures++;
      $display("FAIL mid_both_full inv=%b outv=%b exp=1 0010", ep_in_valid, ch_out_valid);
    end
    // Reset with downstream ready and a requester present: nothing may move.
    rstn         = 1'b0;
    ep_in_ready  = 1'b1;
    ch_out_ready = 4'b1111;
    ch_in_valid  = 4'b0001;
    #1;
    checks++;
    if (ch_in_ready !== 4'b0000 || ep_out_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_ready chr=%b epr=%b exp=0000 0", ch_in_ready, ep_out_ready);
    end
    tick();
    ch_in_valid = '0;
    #1;
    checks++;
    if (ep_in_valid !== 1'b0 || ch_out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_valids inv=%b outv=%b exp=0 0000", ep_in_valid, ch_out_valid);
    end
    rstn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ep_in_valid !== 1'b0 || ch_out_valid !== 4'b0000) begin
        failures++;
        $display("FAIL mid_no_replay_%0d inv=%b outv=%b exp=0 0000", c, ep_in_valid,
                 ch_out_valid);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_egress();
    test_bad_tag();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cosim_ep_channel_arbiter.md
Name: cosim_ep_channel_arbiter

Overview:
Shares one cosim DPI endpoint between NUM_CHANNELS independent ESI valid/ready channel pairs.
- Ingress (HW→host): a round-robin arbiter selects one channel per message and prefixes an 8-bit channel tag.
- Egress (host→HW): the tag is stripped and the payload is steered to the addressed channel.
- The block sits between the ESI channel users and a single endpoint instance whose TYPE_SIZE_BITS = PAYLOAD_BITS+8.

Parameters:
- NUM_CHANNELS, 4, number of shared channels; legal range 1..256.
- PAYLOAD_BITS, 32, per-channel message width; legal range ≥1.
- EP_BITS (localparam), PAYLOAD_BITS+8, endpoint message width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- ch_in_valid  in  NUM_CHANNELS  per-channel HW→host message valid
- ch_in_ready  out  NUM_CHANNELS  per-channel accept
- ch_in_data  in  NUM_CHANNELS*PAYLOAD_BITS  flattened payloads; channel i occupies [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- ch_out_valid  out  NUM_CHANNELS  per-channel host→HW valid
- ch_out_ready  in  NUM_CHANNELS  per-channel consumer ready
- ch_out_data  out  PAYLOAD_BITS  egress payload, shared by all channels; qualified by ch_out_valid
- ep_in_valid  out  1  to endpoint DataInValid
- ep_in_ready  in  1  from endpoint DataInReady
- ep_in_data  out  EP_BITS  to endpoint DataIn
- ep_out_valid  in  1  from endpoint DataOutValid
- ep_out_ready  out  1  to endpoint DataOutReady
- ep_out_data  in  EP_BITS  from endpoint DataOut
- drop_count  out  16  count of egress messages with an invalid tag
- msg_count  out  NUM_CHANNELS*32  per-channel ingress message counters

Behaviour:
- Message format: tag in ep_*_data[7:0]; payload in [EP_BITS-1:8]. Tag is byte 0 on the host side.
- Transfer rule: a transfer occurs when valid && ready are high at a posedge. Valid, once raised, is held with stable data until the transfer.

Ingress FSM, states EMPTY and FULL:
- Output register: ep_in_valid, ep_in_data.
- Capture condition: the register may load in EMPTY, or in FULL on the same cycle it transfers (back-to-back, no bubble).
- Grant: the first requesting channel at or after (last_grant+1) mod NUM_CHANNELS.
- Handshake: ch_in_ready is combinational, one-hot on the granted channel, and only when the capture condition holds.
- On capture: the register loads {payload, tag = grant index}; last_grant <= grant; state FULL.
- In FULL with no capture: hold; all ch_in_ready are 0.
- Latency: channel accept to ep_in_valid is 1 cycle. Sustained throughput is 1 msg/cycle when ep_in_ready=1.
- Fairness: with all channels requesting continuously, grants rotate 0,1,...,N-1,0.

Egress FSM, states HOLD_EMPTY and HOLD_FULL:
- Holding register: data plus tag.
- ep_out_ready = (state == HOLD_EMPTY) || (the held message transfers this cycle).
- On ep_out_valid && ep_out_ready: capture ep_out_data.
- If tag < NUM_CHANNELS: state HOLD_FULL. Otherwise discard the message, increment drop_count (saturating at 0xFFFF), and stay HOLD_EMPTY.
- In HOLD_FULL: ch_out_valid[tag] = 1, all other ch_out_valid bits = 0, ch_out_data = held payload.
- On ch_out_ready[tag]: the message transfers. Any other channel's ready is ignored, so no head-of-line bypass.
- Latency: endpoint valid to ch_out_valid is 1 cycle.

Reset (rstn=0 at a posedge):
- Both FSMs go EMPTY; last_grant = NUM_CHANNELS-1, so channel 0 wins first.
- All valid/ready outputs = 0; counters = 0.
- In-flight held messages are dropped, including mid-handshake.
- ep_out_ready = 0 during reset and 1 on the first cycle after.

Boundary conditions:
- NUM_CHANNELS=1: grant is always 0; tag is always 0.
- last_grant wraps from NUM_CHANNELS-1 to 0.
- Ingress and egress are fully independent; simultaneous activity on both is permitted.

Optional Feature:
- Macro: COSIM_ARB_STATS_EN.
- Defined: msg_count[i] increments (wrapping at 2^32) on each ingress capture from channel i, and drop_count is active as above.
- Undefined: msg_count and drop_count are tied to 0, no counter flops are generated, and invalid-tag messages are still discarded silently.

Decomposition:
- Shared package cosim_arb_pkg:
  - CHAN_TAG_BITS = 8
  - COUNTER_BITS = 32
  - DROP_COUNT_BITS = 16
  - function rr_next(req, last) returning the grant index
- Sub-module cosim_rr_arbiter: parameterised NUM_REQ; request vector in; grant index and grant_valid out; last-grant register updated on an advance input. The ingress path instantiates it.

Test Plan:
- Reset release, no traffic → all outputs 0, ep_out_ready=1 on the cycle after rstn rises. Channel 2 then sends 0xDEADBEEF → next cycle ep_in_valid=1, ep_in_data={0xDEADBEEF, 8'h02}.
- All 4 channels valid continuously, ep_in_ready=1 → tags 0,1,2,3,0,1 on consecutive cycles; no idle cycles.
- ep_in_ready=0 for 5 cycles while ch1 and ch3 request → ep_in_data stable, ch_in_ready=0. After release, tags 1 then 3.
- Endpoint delivers {0x12345678, 8'h03}, ch_out_ready[3]=0 for 3 cycles → ch_out_valid=4'b1000 held and ep_out_ready=0; then ready → transfer; ep_out_ready=1 the same cycle.
- Endpoint delivers tag 8'h09 with NUM_CHANNELS=4 → no ch_out_valid; with COSIM_ARB_STATS_EN defined, drop_count=1.
- Assert rstn=0 while both FSMs are FULL → next cycle all valids=0; the held messages are never emitted.
